bank_biu_linefill_rd: RTL and testbench

Bank-side read bus interface for linefills. It accepts linefill requests from the htu and issues AXI4 read bursts (2 x 128-bit beats per 256-bit line) with ARID = {set,way}. It assembles the returned beats into a full line and delivers it to the isu on the biu_isu_r* channel. It directly feeds the isu linefill buffer and the in-flight array clear.

---
 rtl/bank_biu_pkg.sv | 18 +
 rtl/bank_biu_linefill_rd_if.sv | 57 +++++
 rtl/bank_biu_lf_req_fifo.sv | 49 ++++
 rtl/bank_biu_linefill_rd.sv | 181 ++++++++++++++++++
 tb/tb_bank_biu_linefill_rd.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_biu_pkg.sv
// Shared constants and types for the bank-side linefill read bus interface.
package bank_biu_pkg;

  localparam int LF_ID_WIDTH   = 6;
  localparam int LF_BEAT_WIDTH = 128;
  localparam int LF_LINE_WIDTH = 256;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] LF_ARLEN       = 8'd1;

  typedef enum logic {
    BEAT0 = 1'b0,
    BEAT1 = 1'b1
  } lf_beat_e;

endpackage

// File: rtl/bank_biu_linefill_rd_if.sv
// Bundle of htu request, AXI read (AR/R) and isu line channels for the linefill reader.
interface bank_biu_linefill_rd_if #(
  parameter int ADDR_WIDTH = 32
);
  import bank_biu_pkg::*;

  logic                     htu_biu_lf_valid_i;
  logic                     htu_biu_lf_ready_o;
  logic [ADDR_WIDTH-1:0]    htu_biu_lf_addr_i;
  logic [2:0]               htu_biu_lf_set_i;
  logic [2:0]               htu_biu_lf_way_i;

  logic                     m_arvalid_o;
  logic                     m_arready_i;
  logic [ADDR_WIDTH-1:0]    m_araddr_o;
  logic [LF_ID_WIDTH-1:0]   m_arid_o;
  logic [7:0]               m_arlen_o;
  logic [2:0]               m_arsize_o;
  logic [1:0]               m_arburst_o;

  logic                     m_rvalid_i;
  logic                     m_rready_o;
  logic [LF_BEAT_WIDTH-1:0] m_rdata_i;
  logic [LF_ID_WIDTH-1:0]   m_rid_i;
  logic                     m_rlast_i;
  logic [1:0]               m_rresp_i;

  logic                     biu_isu_rvalid_o;
  logic                     biu_isu_rready_i;
  logic [LF_LINE_WIDTH-1:0] biu_isu_rdata_o;
  logic [LF_ID_WIDTH-1:0]   biu_isu_rid_o;

  // Block-side view
  modport slave (
    input  htu_biu_lf_valid_i, htu_biu_lf_addr_i, htu_biu_lf_set_i, htu_biu_lf_way_i,
    output htu_biu_lf_ready_o,
    output m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arsize_o, m_arburst_o,
    input  m_arready_i,
    input  m_rvalid_i, m_rdata_i, m_rid_i, m_rlast_i, m_rresp_i,
    output m_rready_o,
    output biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
    input  biu_isu_rready_i
  );

  // Environment-side view
  modport master (
    output htu_biu_lf_valid_i, htu_biu_lf_addr_i, htu_biu_lf_set_i, htu_biu_lf_way_i,
    input  htu_biu_lf_ready_o,
    input  m_arvalid_o, m_araddr_o, m_arid_o, m_arlen_o, m_arsize_o, m_arburst_o,
    output m_arready_i,
    output m_rvalid_i, m_rdata_i, m_rid_i, m_rlast_i, m_rresp_i,
    input  m_rready_o,
    input  biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o,
    output biu_isu_rready_i
  );

endinterface

// File: rtl/bank_biu_lf_req_fifo.sv
// Small synchronous FIFO holding pending linefill requests; full is state-derived (no pop bypass).
module bank_biu_lf_req_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [PW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bank_biu_linefill_rd.sv
// Linefill read BIU: queues htu requests, issues 2-beat AXI bursts, assembles 256-bit lines for the isu.
// Optional BANK_BIU_LF_PERF_EN adds delivered-line and inflight high-water counters.
module bank_biu_linefill_rd
  import bank_biu_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  bank_biu_linefill_rd_if.slave                  bus,
  output logic                                   lf_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   lf_inflight_cnt_o
`ifdef BANK_BIU_LF_PERF_EN
  ,
  output logic [31:0]                            lf_perf_lines_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   lf_perf_max_inflight_o
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int FW = ADDR_WIDTH + LF_ID_WIDTH;

  logic [FW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_empty, fifo_full;
  logic          req_hs, ar_hs;
  logic          lf_addr_unused;

  // ---------------------------------------------------------------- request queue / AR
  // Line offset bits are dropped at enqueue so the head is already AR-ready.
  assign fifo_wdata     = {bus.htu_biu_lf_set_i, bus.htu_biu_lf_way_i,
                           bus.htu_biu_lf_addr_i[ADDR_WIDTH-1:5], 5'b0};
  assign lf_addr_unused = ^bus.htu_biu_lf_addr_i[4:0];
  assign req_hs         = bus.htu_biu_lf_valid_i & bus.htu_biu_lf_ready_o;

  bank_biu_lf_req_fifo #(.WIDTH(FW), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_hs),
    .wdata_i (fifo_wdata),
    .pop_i   (ar_hs),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  logic [CW-1:0] cnt_q;

  assign bus.htu_biu_lf_ready_o = ~fifo_full;
  assign bus.m_arvalid_o        = ~fifo_empty & (cnt_q < CW'(MAX_OUTSTANDING));
  assign bus.m_araddr_o         = fifo_rdata[ADDR_WIDTH-1:0];
  assign bus.m_arid_o           = fifo_rdata[FW-1:ADDR_WIDTH];
  assign bus.m_arlen_o          = LF_ARLEN;
  assign bus.m_arsize_o         = AXI_SIZE_16B;
  assign bus.m_arburst_o        = AXI_BURST_INCR;
  assign ar_hs                  = bus.m_arvalid_o & bus.m_arready_i;

  // ---------------------------------------------------------------- beat FSM
  lf_beat_e                 state_q, state_d;
  logic [LF_BEAT_WIDTH-1:0] lo_data_q;
  logic [LF_ID_WIDTH-1:0]   lo_id_q;
  logic                     short_pend_q;
  logic                     out_vld_q;
  logic [LF_LINE_WIDTH-1:0] out_data_q;
  logic [LF_ID_WIDTH-1:0]   out_id_q;
  logic                     err_q;

  logic                     rready, r_hs, beat0_hs, beat1_hs, short_hs, last_hs;
  logic                     out_free, out_hs, line_ld, err_set;
  logic [LF_LINE_WIDTH-1:0] line_data;

  assign out_hs   = out_vld_q & bus.biu_isu_rready_i;
  assign out_free = ~out_vld_q | bus.biu_isu_rready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= BEAT0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rready    = 1'b0;
    beat0_hs  = 1'b0;
    beat1_hs  = 1'b0;
    short_hs  = 1'b0;
    line_ld   = 1'b0;
    line_data = {{LF_BEAT_WIDTH{1'b0}}, lo_data_q};
    unique case (state_q)
      BEAT0: begin
        // A truncated burst parks in lo until the output register can take it.
        rready   = ~short_pend_q;
        beat0_hs = bus.m_rvalid_i & rready;
        short_hs = beat0_hs & bus.m_rlast_i;
        line_ld  = short_pend_q & out_free;
        if (beat0_hs && !bus.m_rlast_i) state_d = BEAT1;
      end
      BEAT1: begin
        rready    = out_free;
        beat1_hs  = bus.m_rvalid_i & rready;
        line_ld   = beat1_hs;
        line_data = {bus.m_rdata_i, lo_data_q};
        if (beat1_hs) state_d = BEAT0;
      end
      default: state_d = BEAT0;
    endcase
  end

  assign bus.m_rready_o = rready;
  assign r_hs           = bus.m_rvalid_i & rready;
  assign last_hs        = short_hs | beat1_hs;
  assign err_set        = (r_hs & (bus.m_rresp_i != AXI_RESP_OKAY)) | short_hs |
                          (beat1_hs & (~bus.m_rlast_i | (bus.m_rid_i != lo_id_q)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lo_data_q    <= '0;
      lo_id_q      <= '0;
      short_pend_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (beat0_hs) begin
        lo_data_q <= bus.m_rdata_i;
        lo_id_q   <= bus.m_rid_i;
      end
      if (short_hs)     short_pend_q <= 1'b1;
      else if (line_ld) short_pend_q <= 1'b0;
      if (line_ld) begin
        out_vld_q  <= 1'b1;
        out_data_q <= line_data;
        out_id_q   <= lo_id_q;
      end else if (out_hs) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
        out_id_q   <= '0;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.biu_isu_rvalid_o = out_vld_q;
  assign bus.biu_isu_rdata_o  = out_data_q;
  assign bus.biu_isu_rid_o    = out_id_q;
  assign lf_err_o             = err_q;

  // ---------------------------------------------------------------- outstanding count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else begin
      unique case ({ar_hs, last_hs & (cnt_q != '0)})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign lf_inflight_cnt_o = cnt_q;

`ifdef BANK_BIU_LF_PERF_EN
  logic [31:0]   perf_lines_q;
  logic [CW-1:0] perf_max_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_lines_q <= '0;
      perf_max_q   <= '0;
    end else begin
      if (out_hs && (perf_lines_q != 32'hFFFF_FFFF)) perf_lines_q <= perf_lines_q + 32'd1;
      if (cnt_q > perf_max_q) perf_max_q <= cnt_q;
    end
  end

  assign lf_perf_lines_o        = perf_lines_q;
  assign lf_perf_max_inflight_o = perf_max_q;
`endif

endmodule

// File: tb/tb_bank_biu_linefill_rd.sv
// Self-checking bench: directed scenarios plus a randomized phase against a queue-based model.
module tb_bank_biu_linefill_rd;
  import bank_biu_pkg::*;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int CW    = $clog2(MAXO+1);

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bank_biu_linefill_rd_if #(.ADDR_WIDTH(AW)) bus ();
  logic          lf_err_o;
  logic [CW-1:0] lf_inflight_cnt_o;
`ifdef BANK_BIU_LF_PERF_EN
  logic [31:0]   lf_perf_lines_o;
  logic [CW-1:0] lf_perf_max_inflight_o;
`endif

  bank_biu_linefill_rd #(.ADDR_WIDTH(AW), .REQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .bus               (bus.slave),
    .lf_err_o          (lf_err_o),
`ifdef BANK_BIU_LF_PERF_EN
    .lf_perf_lines_o        (lf_perf_lines_o),
    .lf_perf_max_inflight_o (lf_perf_max_inflight_o),
`endif
    .lf_inflight_cnt_o (lf_inflight_cnt_o)
  );

  typedef struct { logic [31:0] addr; logic [5:0] id; } req_t;
  typedef struct { logic [5:0] id; logic [127:0] b0; logic [127:0] b1; logic [1:0] resp1; bit short_b; } burst_t;
  typedef struct { logic [5:0] id; logic [255:0] data; } line_t;

  req_t   stim_q[$];
  req_t   fifo_q[$];
  burst_t burst_q[$];
  line_t  line_q[$];

  int checks = 0, errors = 0;
  int m_cnt = 0, ar_hs_n = 0, lines_n = 0, beat = 0, r_budget = 1000000;
  bit m_err = 0, r_vld = 0, use_ab = 0, inj_short = 0;
  logic [1:0] inj_resp = 2'b00;
  int req_mode = 1, ar_mode = 1, r_mode = 1, isu_mode = 1;

  localparam logic [127:0] BEAT_A = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] BEAT_B = {4{32'hBBBB_BBBB}};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int m);
    return (m == 2) ? logic'($urandom_range(0, 1)) : (m == 1);
  endfunction

  // One clock of the environment: check registered state, drive inputs, score handshakes.
  task automatic tick();
    bit push, ar, rh, oh;
    burst_t b;
    @(negedge clk_i);
    chk("inflight_cnt", lf_inflight_cnt_o, m_cnt);
    chk("lf_ready", bus.htu_biu_lf_ready_o, fifo_q.size() < DEPTH);
    chk("arvalid", bus.m_arvalid_o, (fifo_q.size() > 0) && (m_cnt < MAXO));
    chk("lf_err", lf_err_o, m_err);

    bus.htu_biu_lf_valid_i = (stim_q.size() > 0) && pick(req_mode);
    if (stim_q.size() > 0) begin
      bus.htu_biu_lf_addr_i = stim_q[0].addr;
      bus.htu_biu_lf_set_i  = stim_q[0].id[5:3];
      bus.htu_biu_lf_way_i  = stim_q[0].id[2:0];
    end
    bus.m_arready_i = pick(ar_mode);
    if (!r_vld && burst_q.size() > 0 && r_budget > 0 && pick(r_mode)) r_vld = 1;
    bus.m_rvalid_i = r_vld;
    if (burst_q.size() > 0) begin
      b = burst_q[0];
      bus.m_rdata_i = beat ? b.b1 : b.b0;
      bus.m_rid_i   = b.id;
      bus.m_rlast_i = b.short_b || (beat == 1);
      bus.m_rresp_i = beat ? b.resp1 : 2'b00;
    end
    bus.biu_isu_rready_i = pick(isu_mode);
    #1;
    push = bus.htu_biu_lf_valid_i && bus.htu_biu_lf_ready_o;
    ar   = bus.m_arvalid_o && bus.m_arready_i;
    rh   = bus.m_rvalid_i && bus.m_rready_o;
    oh   = bus.biu_isu_rvalid_o && bus.biu_isu_rready_i;

    if (oh) begin
      if (line_q.size() == 0) chk("unexpected_line", oh, 1'b0);
      else begin
        chk("line_data", bus.biu_isu_rdata_o, line_q[0].data);
        chk("line_id", bus.biu_isu_rid_o, line_q[0].id);
        void'(line_q.pop_front());
      end
      lines_n++;
    end
    if (rh) begin
      b = burst_q[0];
      r_vld = 0;
      if (b.short_b || beat == 1) begin
        line_q.push_back('{id: b.id, data: b.short_b ? {128'h0, b.b0} : {b.b1, b.b0}});
        if (b.short_b || b.resp1 != 2'b00) m_err = 1;
        void'(burst_q.pop_front());
        m_cnt--;
        r_budget--;
        beat = 0;
      end else beat = 1;
    end
    if (ar) begin
      chk("araddr", bus.m_araddr_o, {fifo_q[0].addr[31:5], 5'b0});
      chk("arid", bus.m_arid_o, fifo_q[0].id);
      chk("ar_fields", {bus.m_arlen_o, bus.m_arsize_o, bus.m_arburst_o}, {8'd1, 3'b100, 2'b01});
      b.id      = fifo_q[0].id;
      b.b0      = use_ab ? BEAT_A : {$urandom, $urandom, $urandom, $urandom};
      b.b1      = use_ab ? BEAT_B : {$urandom, $urandom, $urandom, $urandom};
      b.resp1   = inj_resp;
      b.short_b = inj_short;
      inj_resp  = 2'b00;
      inj_short = 0;
      burst_q.push_back(b);
      void'(fifo_q.pop_front());
      m_cnt++;
      ar_hs_n++;
    end
    if (push) fifo_q.push_back(stim_q.pop_front());
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while ((stim_q.size() + fifo_q.size() + burst_q.size() + line_q.size()) > 0 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, stim_q.size() + fifo_q.size() + burst_q.size() + line_q.size(), 0);
  endtask

  initial begin
    int base;
    bus.htu_biu_lf_valid_i = 0; bus.htu_biu_lf_addr_i = '0;
    bus.htu_biu_lf_set_i = '0;  bus.htu_biu_lf_way_i = '0;
    bus.m_arready_i = 0; bus.m_rvalid_i = 0; bus.m_rdata_i = '0;
    bus.m_rid_i = '0; bus.m_rlast_i = 0; bus.m_rresp_i = '0;
    bus.biu_isu_rready_i = 0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_lf_ready", bus.htu_biu_lf_ready_o, 1'b1);
    chk("rst_arvalid", bus.m_arvalid_o, 1'b0);
    chk("rst_rready", bus.m_rready_o, 1'b1);
    chk("rst_isu_rvalid", bus.biu_isu_rvalid_o, 1'b0);
    chk("rst_isu_rdata", bus.biu_isu_rdata_o, 256'h0);
    chk("rst_isu_rid", bus.biu_isu_rid_o, 6'h0);
    chk("rst_lf_err", lf_err_o, 1'b0);
    chk("rst_cnt", lf_inflight_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i);
    #1;

    // Single request: AR fields one cycle after the push
    ar_mode = 1; r_mode = 0; isu_mode = 1; use_ab = 1;
    stim_q.push_back('{addr: 32'h1000_0047, id: 6'h1D});
    tick();
    chk("t1_arvalid", bus.m_arvalid_o, 1'b1);
    chk("t1_araddr", bus.m_araddr_o, 32'h1000_0040);
    chk("t1_arid", bus.m_arid_o, 6'h1D);
    chk("t1_arlen", bus.m_arlen_o, 8'd1);
    tick();
    chk("t1_cnt", lf_inflight_cnt_o, 1);

    // Two beats assemble into {B,A}, visible the cycle after beat 1
    r_mode = 1;
    tick();
    tick();
    chk("t2_isu_rvalid", bus.biu_isu_rvalid_o, 1'b1);
    chk("t2_isu_rdata", bus.biu_isu_rdata_o, {BEAT_B, BEAT_A});
    chk("t2_isu_rid", bus.biu_isu_rid_o, 6'h1D);
    chk("t2_cnt", lf_inflight_cnt_o, 0);
    tick();
    chk("t2_isu_rvalid_clr", bus.biu_isu_rvalid_o, 1'b0);
    use_ab = 0;

    // FIFO fills with AR stalled; a fifth request is refused
    ar_mode = 0;
    for (int i = 0; i < 4; i++) stim_q.push_back('{addr: 32'h2000_0000 + 32'(i * 32 + 7), id: 6'(i + 8)});
    repeat (4) tick();
    chk("t3_full_ready", bus.htu_biu_lf_ready_o, 1'b0);
    stim_q.push_back('{addr: 32'h2000_1000, id: 6'h2A});
    repeat (2) tick();
    chk("t3_fifth_held", stim_q.size(), 1);
    chk("t3_head_addr", bus.m_araddr_o, 32'h2000_0000);
    chk("t3_head_id", bus.m_arid_o, 6'h08);
    ar_mode = 1;
    drain("t3_drain", 300);

    // Outstanding cap: 9 requests, no R returns
    r_budget = 0;
    base = ar_hs_n;
    for (int i = 0; i < 9; i++) stim_q.push_back('{addr: $urandom, id: 6'($urandom)});
    repeat (30) tick();
    chk("t4_ar_count8", ar_hs_n - base, 8);
    chk("t4_cnt8", lf_inflight_cnt_o, 8);
    chk("t4_arvalid0", bus.m_arvalid_o, 1'b0);
    r_budget = 1;
    repeat (10) tick();
    chk("t4_ar_count9", ar_hs_n - base, 9);

    // isu backpressure: beat1 of the next burst waits for the line handshake
    r_budget = 1000000; isu_mode = 0;
    repeat (8) tick();
    chk("t5_isu_rvalid", bus.biu_isu_rvalid_o, 1'b1);
    chk("t5_rready_low", bus.m_rready_o, 1'b0);
    chk("t5_beat1_wait", beat, 1);
    isu_mode = 1;
    drain("t5_drain", 300);

    // Error cases: bad resp on beat1, then rlast on beat0
    inj_resp = 2'b10;
    stim_q.push_back('{addr: 32'h3000_0020, id: 6'h11});
    drain("t6a_drain", 100);
    chk("t6a_err", lf_err_o, 1'b1);
    inj_short = 1;
    stim_q.push_back('{addr: 32'h3000_0040, id: 6'h22});
    drain("t6b_drain", 100);
    chk("t6b_err_sticky", lf_err_o, 1'b1);
    chk("t6b_cnt", lf_inflight_cnt_o, 0);

    // Randomized traffic with random handshakes on every channel
    req_mode = 2; ar_mode = 2; r_mode = 2; isu_mode = 2;
    for (int i = 0; i < 80; i++) stim_q.push_back('{addr: $urandom, id: 6'($urandom)});
    drain("rand_drain", 5000);
    chk("final_cnt", lf_inflight_cnt_o, 0);
    chk("final_err", lf_err_o, 1'b1);
`ifdef BANK_BIU_LF_PERF_EN
    chk("perf_lines", lf_perf_lines_o, lines_n);
    chk("perf_max", lf_perf_max_inflight_o, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
